rdcla_arbiter: RTL and testbench
================================

// Module: rdcla_arbiter
// PURPOSE
//  Shares one pipelined 32-bit radix-2 CLA adder (rdcla) between two requesters (req0, req1).
//  Arbitrates round-robin and drives the adder operands and cin (cin=1 gives a-b).
//  Returns sum and cout, tagged with the requester id, on a valid/ready response channel.
//  The adder forms sum from live operands XOR delayed carries, so operands must stay stable
//  for the full carry latency. This block therefore issues one op at a time and holds operands.
// PARAMETERS
//  WIDTH    32  operand width; must equal the rdcla width (32)
//  LATENCY  6   clk edges from operands stable at rdcla to valid sum/cout (kpg_init + 5 kpg ranks)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  req0_valid  in   1      requester 0 has an op
//  req0_ready  out  1      requester 0 op accepted this cycle
//  req0_a      in   WIDTH  operand a
//  req0_b      in   WIDTH  operand b
//  req0_sub    in   1      1 = a-b, 0 = a+b
//  req1_*      -    -      same five signals for requester 1
//  add_a       out  WIDTH  to rdcla a
//  add_b       out  WIDTH  to rdcla b_in
//  add_cin     out  1      to rdcla cin
//  add_sum     in   WIDTH  from rdcla sum
//  add_cout    in   1      from rdcla cout
//  rsp_valid   out  1      result available
//  rsp_ready   in   1      consumer accepts result
//  rsp_id      out  1      requester that owns the result
//  rsp_sum     out  WIDTH  registered result
//  rsp_cout    out  1      registered carry out (sub: 1 = no borrow)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, last_grant=1 (req0 wins first).
//   add_a/add_b/add_cin=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0. No op survives reset.
//  FSM states: IDLE, BUSY, RESP.
//  accept = (state==IDLE) | (state==RESP & rsp_ready).
//  grant: if only one requester is valid, it wins. If both are valid, the one != last_grant wins.
//  reqN_ready = accept & grantN. It is combinational and may depend on reqN_valid.
//   reqN_valid must not depend on ready.
//  Handshake (valid&ready) in cycle T: register a, b, sub into add_a, add_b, add_cin;
//   latch the id; update last_grant; go to BUSY with cnt=0.
//  BUSY: cnt increments each cycle. add_* are held constant from T+1 until the next grant.
//  BUSY with cnt==LATENCY (cycle T+1+LATENCY): capture add_sum/add_cout into rsp_sum/rsp_cout;
//   go to RESP.
//  RESP: rsp_valid=1. rsp_* are stable while rsp_ready=0; no new grant is made meanwhile.
//  RESP & rsp_ready: clear rsp_valid.
//   If any req is valid, grant it in the same cycle and go to BUSY; otherwise go to IDLE.
//  Timing: grant -> rsp_valid = LATENCY+2 cycles (8).
//   Back-to-back period is LATENCY+2 when rsp_ready=1.
//  Arithmetic: modulo 2^WIDTH.
//   add: {cout,sum} = a+b.
//   sub: {cout,sum} = a+~b+1 (cout=1 iff a>=b unsigned).
//  Simultaneous events: the RESP handshake and a new grant in the same cycle are legal.
//   A requester that drops valid before ready is not granted; no grant is latched.
// STRUCTURE
//  Shared package rdcla_pkg holds:
//   state encoding localparams ST_IDLE/ST_BUSY/ST_RESP, RDCLA_WIDTH=32, RDCLA_LATENCY=6.
//  Sub-module rr_arb2: 2-way round-robin grant from valids + last_grant.
//  The rdcla instance is outside this block and is wired by the parent.
// TESTING (bench instantiates rdcla + rdcla_arbiter)
//  1. req0 a=5 b=3 sub=0 -> rsp_valid 8 cycles after grant; id=0, sum=8, cout=0.
//  2. req1 a=5 b=3 sub=1 -> sum=2, cout=1.
//     Then a=3 b=5 sub=1 -> sum=0xFFFF_FFFE, cout=0.
//  3. a=0xFFFF_FFFF b=1 add -> sum=0, cout=1.
//     Check add_a/add_b are constant from grant+1 until the RESP handshake.
//  4. Both valid continuously, rsp_ready=1 -> grants 0,1,0,1; one response every 8 cycles.
//     Ids alternate; no req_ready outside accept.
//  5. rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both req_ready=0.
//     Release -> next grant in the same cycle.
//  6. Assert rst in BUSY cnt=3 -> all outputs at reset values immediately.
//     After release, the op from test 1 gives the correct result; req0 is granted first.

Source files
------------

// File: rtl/rdcla_pkg.sv
// Shared definitions for the rdcla adder and the arbiter that time-shares it.
package rdcla_pkg;

  localparam int RDCLA_WIDTH   = 32;
  // Clock edges from stable operands at the adder to a valid sum/cout.
  localparam int RDCLA_LATENCY = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rdcla_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; when both ask,
// the one that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Grant vector is one-hot or zero by construction.
  assign grant[0] = valid[0] & (~valid[1] | last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/rdcla_arbiter.sv
// Shares one pipelined CLA adder between two requesters. One op is in flight
// at a time because the adder XORs live operands with delayed carries, so the
// operands must be held for the whole carry latency.
module rdcla_arbiter
  import rdcla_pkg::*;
#(
  parameter int WIDTH   = RDCLA_WIDTH,
  parameter int LATENCY = RDCLA_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             op_id;
  logic             accept;
  logic [1:0]       grant;
  logic             hs0;
  logic             hs1;
  logic             start;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // A new op may start when idle, or when the pending result leaves this cycle.
  assign accept     = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready);
  assign req0_ready = accept & grant[0];
  assign req1_ready = accept & grant[1];
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;
  assign start      = hs0 | hs1;

  // Control FSM plus all registered outputs: operand hold, result capture, response handshake.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are reset too, so the adder sees zero operands and no stale result escapes.
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (cnt == CNT_W'(LATENCY)) begin
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= start ? ST_BUSY : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A grant only happens when accept is high, so this never disturbs an op in flight.
      if (start) begin
        add_a      <= hs1 ? req1_a : req0_a;
        add_b      <= hs1 ? req1_b : req0_b;
        add_cin    <= hs1 ? req1_sub : req0_sub;
        op_id      <= hs1;
        last_grant <= hs1;
        cnt        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rdcla_arbiter.sv
// Bench for rdcla_arbiter with a behavioural pipelined adder standing in for rdcla.
module tb_rdcla_arbiter;
  import rdcla_pkg::*;

  localparam int W   = RDCLA_WIDTH;
  localparam int LAT = RDCLA_LATENCY;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  always #5 clk = ~clk;

  rdcla_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  // Adder stand-in: result of the live operands, visible LAT edges later.
  logic [W:0] add_pipe [LAT];
  always @(posedge clk) begin
    add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b ^ {W{add_cin}}} + {{W{1'b0}}, add_cin};
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign add_sum  = add_pipe[LAT-1][W-1:0];
  assign add_cout = add_pipe[LAT-1][W];

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } op_t;

  typedef struct {
    logic         id;
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    int           gcyc;
  } exp_t;

  op_t  q0[$], q1[$];
  exp_t sb[$];
  int   grant_id_log[$], grant_cyc_log[$], hs_cyc_log[$];
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic op_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                             input logic [W-1:0] sum, input logic cout);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.sum = sum; o.cout = cout;
    return o;
  endfunction

  function automatic exp_t to_exp(input op_t o, input logic id, input int gcyc);
    exp_t e;
    e.id = id; e.a = o.a; e.b = o.b; e.sub = o.sub; e.sum = o.sum; e.cout = o.cout; e.gcyc = gcyc;
    return e;
  endfunction

  // Present queued ops on both requesters; valid stays high until each op is taken.
  task automatic drive_all(input int max_cyc);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < max_cyc) begin
      @(posedge clk); #1;
      req0_valid = q0.size() > 0;
      if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_sub = q0[0].sub; end
      req1_valid = q1.size() > 0;
      if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_sub = q1[0].sub; end
      @(negedge clk); #1;
      if (req0_valid && req1_valid) check("single_grant", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_valid && req0_ready) begin
        sb.push_back(to_exp(q0[0], 1'b0, cyc));
        grant_id_log.push_back(0); grant_cyc_log.push_back(cyc);
        void'(q0.pop_front());
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(to_exp(q1[0], 1'b1, cyc));
        grant_id_log.push_back(1); grant_cyc_log.push_back(cyc);
        void'(q1.pop_front());
      end
      k++;
    end
    check("drive_timeout", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while (sb.size() > 0 && k < max_cyc) begin @(negedge clk); k++; end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic clear_logs();
    grant_id_log.delete(); grant_cyc_log.delete(); hs_cyc_log.delete();
  endtask

  // Monitor: pops the scoreboard on each response handshake and watches invariants.
  logic         prev_valid = 1'b0;
  int           first_cyc = 0;
  logic [W-1:0] hold_sum;
  logic         hold_cout, hold_id, acc_exp;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      acc_exp = (sb.size() == 0 && !rsp_valid) || (rsp_valid && rsp_ready);
      if (req0_ready || req1_ready) check("ready_only_on_accept", 32'd1, 32'(acc_exp));
      if (sb.size() > 0 && cyc > sb[0].gcyc) begin
        check("add_a_held",   add_a,          sb[0].a);
        check("add_b_held",   add_b,          sb[0].b);
        check("add_cin_held", 32'(add_cin),   32'(sb[0].sub));
      end
      if (rsp_valid && !prev_valid) begin
        first_cyc = cyc; hold_sum = rsp_sum; hold_cout = rsp_cout; hold_id = rsp_id;
      end
      if (rsp_valid && !rsp_ready) begin
        check("stall_req0_ready", 32'(req0_ready), 32'd0);
        check("stall_req1_ready", 32'(req1_ready), 32'd0);
        if (prev_valid) begin
          check("stall_sum_stable",  rsp_sum,        hold_sum);
          check("stall_cout_stable", 32'(rsp_cout),  32'(hold_cout));
          check("stall_id_stable",   32'(rsp_id),    32'(hold_id));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id",      32'(rsp_id),          32'(e.id));
          check("rsp_sum",     rsp_sum,              e.sum);
          check("rsp_cout",    32'(rsp_cout),        32'(e.cout));
          check("rsp_latency", 32'(first_cyc - e.gcyc), 32'(LAT + 2));
          hs_cyc_log.push_back(cyc);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_add_a"},     add_a,          32'd0);
    check({tag, "_add_b"},     add_b,          32'd0);
    check({tag, "_add_cin"},   32'(add_cin),   32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({tag, "_rsp_sum"},   rsp_sum,        32'd0);
    check({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int k;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp_ready  = 1'b1;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b0;

    // 1: single add on req0.
    q0.push_back(mk(32'd5, 32'd3, 1'b0, 32'd8, 1'b0));
    drive_all(50); drain(50);

    // 2: subtractions on req1, with and without borrow.
    q1.push_back(mk(32'd5, 32'd3, 1'b1, 32'd2, 1'b1));
    q1.push_back(mk(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0));
    drive_all(100); drain(50);

    // 3: carry out of the top bit; operand hold is watched by the monitor.
    q1.push_back(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1));
    drive_all(50); drain(50);

    // 4: both requesters busy, consumer always ready.
    clear_logs();
    q0.push_back(mk(32'd10, 32'd20, 1'b0, 32'd30, 1'b0));
    q0.push_back(mk(32'd100, 32'd1, 1'b1, 32'd99, 1'b1));
    q1.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 1'b1));
    q1.push_back(mk(32'd7, 32'd8, 1'b1, 32'hFFFF_FFFF, 1'b0));
    drive_all(200); drain(50);
    check("t4_grant_count", 32'(grant_id_log.size()), 32'd4);
    for (int i = 0; i < grant_id_log.size() && i < 4; i++)
      check("t4_grant_order", 32'(grant_id_log[i]), 32'(i % 2));
    check("t4_rsp_count", 32'(hs_cyc_log.size()), 32'd4);
    for (int i = 1; i < hs_cyc_log.size(); i++)
      check("t4_rsp_period", 32'(hs_cyc_log[i] - hs_cyc_log[i-1]), 32'(LAT + 2));

    // 5: consumer stalls five cycles in RESP; next grant lands on the release cycle.
    clear_logs();
    rsp_ready = 1'b0;
    q0.push_back(mk(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0));
    q1.push_back(mk(32'd1, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0));
    fork
      drive_all(200);
      begin
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        check("t5_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    rsp_ready = 1'b1;
    check("t5_grant_count", 32'(grant_cyc_log.size()), 32'd2);
    check("t5_hs_count", 32'(hs_cyc_log.size()), 32'd1);
    if (grant_cyc_log.size() == 2 && hs_cyc_log.size() >= 1)
      check("t5_grant_on_release", 32'(grant_cyc_log[1]), 32'(hs_cyc_log[0]));
    drain(50);

    // 6: reset mid-op (BUSY, cnt=3), then the same op again with both requesters asking.
    clear_logs();
    q0.push_back(mk(32'd5, 32'd3, 1'b0, 32'd8, 1'b0));
    drive_all(50);
    check("t6_grant_count", 32'(grant_cyc_log.size()), 32'd1);
    g = (grant_cyc_log.size() > 0) ? grant_cyc_log[0] : cyc;
    while (cyc < g + 4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_reset_outputs("midop_reset");
    sb.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    clear_logs();
    q0.push_back(mk(32'd5, 32'd3, 1'b0, 32'd8, 1'b0));
    q1.push_back(mk(32'd10, 32'd5, 1'b1, 32'd5, 1'b1));
    drive_all(100); drain(50);
    check("t6_grant_count_after", 32'(grant_id_log.size()), 32'd2);
    if (grant_id_log.size() > 0) check("t6_first_grant_req0", 32'(grant_id_log[0]), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
